csa_frame_accumulator: RTL
==========================

# csa_frame_accumulator

Sequencing controller for the team's 4-operand carry-save adder datapath. It accepts a stream of W-bit operands over a valid/ready handshake and packs them into groups of four. Each group is reduced through one carry-save stage plus a final ripple stage. Group sums are accumulated over a frame of up to GROUPS groups, and the frame total is presented on a valid/ready output port. It sits between an operand source (e.g. a sample FIFO) and any consumer of multi-operand sums.

## Interface
- W, default 4: operand width.
- GROUPS, default 4: maximum groups per frame. Must be ≥ 1 and a power of two.
- GW, derived, W+2: group sum width.
- ACC_W, derived, W+2+$clog2(GROUPS): accumulator and output width. Default 8.
- clk  input  1  single clock. All state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present on in_data.
- in_data  input  W  operand, unsigned.
- in_last  input  1  qualifies the current operand as the final one of the frame. Sampled only on an accepted operand.
- in_ready  output  1  block can accept an operand this cycle.
- out_valid  output  1  frame total valid on out_sum.
- out_sum  output  ACC_W  frame total, unsigned.
- out_ready  input  1  consumer accepts out_sum.
- busy  output  1  high in any state other than COLLECT with zero operands held.

## Operation
- Operand slots: s0..s3, each W bits. Slot index: 2-bit counter slot_cnt. Group counter: grp_cnt, width $clog2(GROUPS)+1. Flag: last_seen.
- Accept condition: in_valid && in_ready at a rising edge. The operand is written to slot[slot_cnt], and slot_cnt increments.
- States:
  - COLLECT: in_ready=1. Go to ADD when the accepted operand fills s3 or carries in_last=1.
  - ADD: in_ready=0.
    - Group sum = s0+s1+s2+s3. It is computed by the CSA stage (s0,s1,s2 full adders), a second stage with s3, and a final ripple stage. The result is GW bits and cannot overflow.
    - acc <= acc + zero-extended group sum. grp_cnt increments, slot_cnt and all slots clear.
    - Go to DONE if last_seen or grp_cnt+1 == GROUPS. Otherwise return to COLLECT.
  - DONE: out_valid=1, out_sum=acc, in_ready=0.
    - On out_ready, clear acc, grp_cnt and last_seen, then go to COLLECT.
- Partial group (in_last before s3 is filled): unfilled slots read as zero.
- Frame of exactly GROUPS full groups: ends without in_last. A set in_last on the final operand is harmless.
- Frame total cannot overflow ACC_W: at most 4·GROUPS·(2^W−1) < 2^ACC_W.
- in_last on the first operand of a frame: frame total equals that operand.
- in_data and in_last are don't-care when in_valid=0. The block ignores in_valid while in_ready=0.

## Timing
- Reset values:
  - State = COLLECT.
  - in_ready=1, out_valid=0, out_sum=0, busy=0.
  - acc, slots, slot_cnt, grp_cnt and last_seen all 0.
- Reset asserted mid-frame or in DONE discards all state immediately, with no output handshake. The first cycle after deassertion accepts operands.
- Group turnaround:
  - Accept the 4th operand at edge T, so the state is ADD in cycle T+1 and in_ready=0 in that cycle.
  - If the frame continues, in_ready=1 again in cycle T+2.
  - Sustained throughput: 4 operands per 5 cycles.
- Frame completion:
  - Closing operand accepted at edge T, ADD in cycle T+1, out_valid=1 from cycle T+2.
  - Latency from closing operand to out_valid is 2 cycles.
- out_valid and out_sum are held stable until out_ready is sampled high.
- out_ready high in the first DONE cycle gives a 1-cycle DONE, and in_ready=1 in the next cycle.
- Back-to-back frames: minimum gap from out handshake to next operand acceptance is 1 cycle.
- out_ready while out_valid=0 is ignored.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset, then 16 operands of 15 back-to-back (in_valid held high), out_ready=1 → in_ready low exactly 1 cycle after every 4th operand; a single out_valid pulse with out_sum=240, 2 cycles after the 16th operand.
- Operands 1,2,3,4 with in_last on 4 → out_sum=10 after 2 cycles; grp_cnt returns to 0; the next frame accepts operands.
- Operands 5,6 with in_last on 6 → out_sum=11 (zero-padded slots); operands 9 with in_last → out_sum=9.
- Frame 1..8 (two groups) with in_last on 8, out_ready held low 5 cycles → out_valid and out_sum=36 stable all 5 cycles, in_ready=0 throughout, in_valid pulses ignored; clears on out_ready.
- Feed 7 operands, assert rst_n=0 for 1 cycle → all outputs at reset values during reset; a following frame of 3,3 with in_last → out_sum=6 (no residue).
- in_valid toggling 1/0 every cycle with operand 2 for 16 operands → out_sum=32; operands sampled only on handshake cycles.

Source files
------------

// File: rtl/csa_frame_accumulator.sv
// Packs a W-bit operand stream into groups of four, reduces each group through a
// carry-save tree plus a ripple stage, and accumulates group sums into a frame total.
module csa_frame_accumulator #(
    parameter int W      = 4,
    parameter int GROUPS = 4,    // must be >= 1 and a power of two
    localparam int GW    = W + 2,
    localparam int ACC_W = W + 2 + $clog2(GROUPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    input  logic             out_ready,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    localparam int GCW = $clog2(GROUPS) + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high. in_ready and out_valid come from registers only, so neither depends
    // combinationally on in_valid or out_ready.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ADD     = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e           state_q;
    logic [W-1:0]     slot_q [4];
    logic [1:0]       slot_cnt_q;
    logic [GCW-1:0]   grp_cnt_q;
    logic             last_seen_q;
    logic [ACC_W-1:0] acc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [GW-1:0] op0, op1, op2, op3;
    logic [GW-1:0] s1_sum, s1_cry, s2_sum, s2_cry, grp_sum;

    function automatic logic [GW-1:0] ripple_add(input logic [GW-1:0] a,
                                                 input logic [GW-1:0] b);
        logic          c;
        logic [GW-1:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < GW; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return s;
    endfunction

    assign op0 = GW'(slot_q[0]);
    assign op1 = GW'(slot_q[1]);
    assign op2 = GW'(slot_q[2]);
    assign op3 = GW'(slot_q[3]);

    // Two 3:2 stages then one carry-propagate add; the true sum fits in GW bits,
    // so dropping carries shifted past the MSB loses nothing.
    assign s1_sum  = op0 ^ op1 ^ op2;
    assign s1_cry  = ((op0 & op1) | (op0 & op2) | (op1 & op2)) << 1;
    assign s2_sum  = s1_sum ^ s1_cry ^ op3;
    assign s2_cry  = ((s1_sum & s1_cry) | (s1_sum & op3) | (s1_cry & op3)) << 1;
    assign grp_sum = ripple_add(s2_sum, s2_cry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            slot_cnt_q  <= '0;
            grp_cnt_q   <= '0;
            last_seen_q <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (in_valid) begin
                        slot_q[slot_cnt_q] <= in_data;
                        slot_cnt_q         <= slot_cnt_q + 2'd1;
                        busy_q             <= 1'b1;
                        if (in_last) last_seen_q <= 1'b1;
                        if (slot_cnt_q == 2'd3 || in_last) begin
                            state_q    <= ST_ADD;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ST_ADD: begin
                    acc_q      <= acc_q + ACC_W'(grp_sum);
                    grp_cnt_q  <= grp_cnt_q + GCW'(1);
                    slot_cnt_q <= '0;
                    for (int i = 0; i < 4; i++) slot_q[i] <= '0;
                    if (last_seen_q || (grp_cnt_q + GCW'(1) == GCW'(GROUPS))) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q    <= ST_COLLECT;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        grp_cnt_q   <= '0;
                        last_seen_q <= 1'b0;
                        state_q     <= ST_COLLECT;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_COLLECT;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = acc_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));
    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_sum)));
    a_busy_collect: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_COLLECT) |-> (busy == (slot_cnt_q != 2'd0)));

endmodule
